// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush, LSU wait stalls, RAW/load-use stalls and forwarding selects.
// Optional feature macro: PIPE_CTRL_FORWARD_EN (operand forwarding; otherwise every RAW hazard stalls).
module pipe_ctrl #(
  parameter int unsigned JUMP_PENALTY = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_addr_id_i,
  input  logic [4:0] rs2_addr_id_i,
  input  logic       rs1_used_id_i,
  input  logic       rs2_used_id_i,
  input  logic [4:0] rd_addr_ex_i,
  input  logic       rd_wr_en_ex_i,
  input  logic       lsu_req_ex_i,
  input  logic       lsu_we_ex_i,
  input  logic       lsu_ready_i,
  input  logic [4:0] rd_addr_wb_i,
  input  logic       rd_wr_en_wb_i,
  input  logic       jump_taken_ex_i,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       flush_id_o,
  output logic       flush_ex_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LSU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [1:0] PEN_LOAD = 2'(JUMP_PENALTY - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic       load_ex;
  logic       rs1_ex_match, rs2_ex_match, rs1_wb_match, rs2_wb_match;
  logic       hazard_stall;
  logic [1:0] fwd_a_calc, fwd_b_calc;

  logic       stall_if_c, stall_id_c, stall_ex_c, flush_id_c, flush_ex_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign load_ex      = lsu_req_ex_i & ~lsu_we_ex_i;
  assign rs1_ex_match = rs1_used_id_i & (rs1_addr_id_i != 5'd0) & rd_wr_en_ex_i & (rs1_addr_id_i == rd_addr_ex_i);
  assign rs2_ex_match = rs2_used_id_i & (rs2_addr_id_i != 5'd0) & rd_wr_en_ex_i & (rs2_addr_id_i == rd_addr_ex_i);
  assign rs1_wb_match = rs1_used_id_i & (rs1_addr_id_i != 5'd0) & rd_wr_en_wb_i & (rs1_addr_id_i == rd_addr_wb_i);
  assign rs2_wb_match = rs2_used_id_i & (rs2_addr_id_i != 5'd0) & rd_wr_en_wb_i & (rs2_addr_id_i == rd_addr_wb_i);

`ifdef PIPE_CTRL_FORWARD_EN
  // A load result is not available in EX, so an EX match on a load neither forwards nor falls back to WB.
  assign hazard_stall = load_ex & (rs1_ex_match | rs2_ex_match);
  assign fwd_a_calc   = rs1_ex_match ? (load_ex ? 2'b00 : 2'b01) : (rs1_wb_match ? 2'b10 : 2'b00);
  assign fwd_b_calc   = rs2_ex_match ? (load_ex ? 2'b00 : 2'b01) : (rs2_wb_match ? 2'b10 : 2'b00);
`else
  assign hazard_stall = rs1_ex_match | rs2_ex_match | rs1_wb_match | rs2_wb_match;
  assign fwd_a_calc   = 2'b00;
  assign fwd_b_calc   = 2'b00;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    stall_ex_c = 1'b0;
    flush_id_c = 1'b0;
    flush_ex_c = 1'b0;
    fwd_a_c    = 2'b00;
    fwd_b_c    = 2'b00;
    case (state_q)
      RUN: begin
        if (jump_taken_ex_i) begin
          flush_id_c = 1'b1;
          flush_ex_c = 1'b1;
          if (JUMP_PENALTY > 1) begin
            cnt_d   = PEN_LOAD;
            state_d = FLUSH;
          end
        end else if (lsu_req_ex_i && !lsu_ready_i) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
          fwd_a_c    = fwd_a_calc;
          fwd_b_c    = fwd_b_calc;
          state_d    = LSU_WAIT;
        end else begin
          fwd_a_c = fwd_a_calc;
          fwd_b_c = fwd_b_calc;
          if (hazard_stall) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
          end
        end
      end
      LSU_WAIT: begin
        fwd_a_c = fwd_a_calc;
        fwd_b_c = fwd_b_calc;
        if (!lsu_ready_i) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_id_c = 1'b1;
        flush_ex_c = 1'b1;
        cnt_d      = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Reset masks the outputs immediately, independent of the registered state.
  assign stall_if_o  = ~rst_i & stall_if_c;
  assign stall_id_o  = ~rst_i & stall_id_c;
  assign stall_ex_o  = ~rst_i & stall_ex_c;
  assign flush_id_o  = ~rst_i & flush_id_c;
  assign flush_ex_o  = ~rst_i & flush_ex_c;
  assign fwd_a_sel_o = rst_i ? 2'b00 : fwd_a_c;
  assign fwd_b_sel_o = rst_i ? 2'b00 : fwd_b_c;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipe_ctrl;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst_i;
  logic [4:0] rs1_addr_id_i, rs2_addr_id_i, rd_addr_ex_i, rd_addr_wb_i;
  logic rs1_used_id_i, rs2_used_id_i, rd_wr_en_ex_i, lsu_req_ex_i, lsu_we_ex_i;
  logic lsu_ready_i, rd_wr_en_wb_i, jump_taken_ex_i;
  logic stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o;
  logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
  logic [8:0] got;

  int errors = 0;
  int checks = 0;
  int m_flush_left = 0;
  bit m_wait = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.JUMP_PENALTY(P)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs1_addr_id_i(rs1_addr_id_i), .rs2_addr_id_i(rs2_addr_id_i),
    .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
    .rd_addr_ex_i(rd_addr_ex_i), .rd_wr_en_ex_i(rd_wr_en_ex_i),
    .lsu_req_ex_i(lsu_req_ex_i), .lsu_we_ex_i(lsu_we_ex_i), .lsu_ready_i(lsu_ready_i),
    .rd_addr_wb_i(rd_addr_wb_i), .rd_wr_en_wb_i(rd_wr_en_wb_i),
    .jump_taken_ex_i(jump_taken_ex_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .flush_id_o(flush_id_o), .flush_ex_o(flush_ex_o),
    .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o)
  );

  assign got = {stall_if_o, stall_id_o, stall_ex_o, flush_id_o, flush_ex_o, fwd_a_sel_o, fwd_b_sel_o};

  // Expected {stall_if, stall_id, stall_ex, flush_id, flush_ex, fwd_a, fwd_b} for the current cycle.
  function automatic logic [8:0] model_out();
    logic h1e, h2e, h1w, h2w, ld, stall;
    logic [1:0] fa, fb;
    if (rst_i) return 9'd0;
    h1e = rs1_used_id_i && rs1_addr_id_i != 5'd0 && rd_wr_en_ex_i && rs1_addr_id_i == rd_addr_ex_i;
    h2e = rs2_used_id_i && rs2_addr_id_i != 5'd0 && rd_wr_en_ex_i && rs2_addr_id_i == rd_addr_ex_i;
    h1w = rs1_used_id_i && rs1_addr_id_i != 5'd0 && rd_wr_en_wb_i && rs1_addr_id_i == rd_addr_wb_i;
    h2w = rs2_used_id_i && rs2_addr_id_i != 5'd0 && rd_wr_en_wb_i && rs2_addr_id_i == rd_addr_wb_i;
    ld  = lsu_req_ex_i && !lsu_we_ex_i;
`ifdef PIPE_CTRL_FORWARD_EN
    fa = h1e ? (ld ? 2'd0 : 2'd1) : (h1w ? 2'd2 : 2'd0);
    fb = h2e ? (ld ? 2'd0 : 2'd1) : (h2w ? 2'd2 : 2'd0);
    stall = ld && (h1e || h2e);
`else
    fa = 2'd0;
    fb = 2'd0;
    stall = h1e || h2e || h1w || h2w;
`endif
    if (m_flush_left > 0) return 9'b00011_0000;
    if (m_wait) return {!lsu_ready_i, !lsu_ready_i, !lsu_ready_i, 2'b00, fa, fb};
    if (jump_taken_ex_i) return 9'b00011_0000;
    if (lsu_req_ex_i && !lsu_ready_i) return {5'b11100, fa, fb};
    if (stall) return {5'b11001, fa, fb};
    return {5'b00000, fa, fb};
  endfunction

  // Advance the model across one rising edge, then move to the input-drive point.
  task automatic tick();
    @(posedge clk);
    if (rst_i) begin
      m_flush_left = 0;
      m_wait = 1'b0;
    end else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
    else if (m_wait) m_wait = !lsu_ready_i;
    else if (jump_taken_ex_i) m_flush_left = P - 1;
    else if (lsu_req_ex_i && !lsu_ready_i) m_wait = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    rs1_addr_id_i = 5'd0; rs2_addr_id_i = 5'd0; rs1_used_id_i = 1'b0; rs2_used_id_i = 1'b0;
    rd_addr_ex_i = 5'd0; rd_wr_en_ex_i = 1'b0; lsu_req_ex_i = 1'b0; lsu_we_ex_i = 1'b0;
    lsu_ready_i = 1'b1; rd_addr_wb_i = 5'd0; rd_wr_en_wb_i = 1'b0; jump_taken_ex_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rs1_addr_id_i = 5'd3; rs1_used_id_i = 1'b1; rd_addr_ex_i = 5'd3; rd_wr_en_ex_i = 1'b1;
      jump_taken_ex_i = 1'($urandom_range(0, 1)); lsu_req_ex_i = 1'b1; lsu_ready_i = 1'b0;
      #2;
      checks++;
      if (got !== 9'd0) begin errors++; $display("FAIL reset cyc%0d got=%b exp=%b", i, got, 9'd0); end
      tick();
    end
    idle_inputs();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_raw();
    int stalls = 0;
    int exp_stalls;
`ifdef PIPE_CTRL_FORWARD_EN
    exp_stalls = 0;
`else
    exp_stalls = 2;
`endif
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      rs1_addr_id_i = 5'd5; rs1_used_id_i = 1'b1;
      if (c == 0) begin rd_addr_ex_i = 5'd5; rd_wr_en_ex_i = 1'b1; end
      if (c == 1) begin rd_addr_wb_i = 5'd5; rd_wr_en_wb_i = 1'b1; end
      @(negedge clk);
      checks++;
      if (got !== model_out()) begin errors++; $display("FAIL raw cyc%0d got=%b exp=%b", c, got, model_out()); end
`ifdef PIPE_CTRL_FORWARD_EN
      if (c == 0) begin
        checks++;
        if (fwd_a_sel_o !== 2'b01) begin errors++; $display("FAIL raw_fwd_ex got=%b exp=01", fwd_a_sel_o); end
      end
`endif
      if (stall_if_o && stall_id_o && flush_ex_o) stalls++;
      tick();
    end
    checks++;
    if (stalls !== exp_stalls) begin errors++; $display("FAIL raw_stall_count got=%0d exp=%0d", stalls, exp_stalls); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      rs2_addr_id_i = 5'd7; rs2_used_id_i = 1'b1; rs1_addr_id_i = 5'd0; rs1_used_id_i = 1'b1;
      if (c == 0) begin rd_addr_ex_i = 5'd7; rd_wr_en_ex_i = 1'b1; lsu_req_ex_i = 1'b1; end
      if (c == 1) begin rd_addr_wb_i = 5'd7; rd_wr_en_wb_i = 1'b1; end
      if (c == 2) begin rd_addr_ex_i = 5'd0; rd_wr_en_ex_i = 1'b1; rs2_used_id_i = 1'b0; end
      @(negedge clk);
      checks++;
      if (got !== model_out()) begin errors++; $display("FAIL load_use cyc%0d got=%b exp=%b", c, got, model_out()); end
      if (c == 0) begin
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, flush_ex_o} !== 4'b1101) begin
          errors++; $display("FAIL load_use_stall got=%b exp=1101", {stall_if_o, stall_id_o, stall_ex_o, flush_ex_o});
        end
      end
`ifdef PIPE_CTRL_FORWARD_EN
      if (c == 1) begin
        checks++;
        if (fwd_b_sel_o !== 2'b10) begin errors++; $display("FAIL load_use_fwd_wb got=%b exp=10", fwd_b_sel_o); end
      end
`endif
      if (stall_if_o) stalls++;
      tick();
    end
  endtask

  task automatic test_jump(input bit with_load_use);
    int flushes = 0;
    for (int c = 0; c < P + 3; c++) begin
      idle_inputs();
      if (c == 0) begin
        jump_taken_ex_i = 1'b1;
        if (with_load_use) begin
          rd_addr_ex_i = 5'd9; rd_wr_en_ex_i = 1'b1; lsu_req_ex_i = 1'b1;
          rs1_addr_id_i = 5'd9; rs1_used_id_i = 1'b1;
        end
      end else begin
        jump_taken_ex_i = 1'($urandom_range(0, 1)) & (c < P);
      end
      @(negedge clk);
      checks++;
      if (got !== model_out()) begin errors++; $display("FAIL jump%0d cyc%0d got=%b exp=%b", with_load_use, c, got, model_out()); end
      if (c == 0 && with_load_use) begin
        checks++;
        if ({stall_if_o, stall_id_o, flush_id_o, flush_ex_o} !== 4'b0011) begin
          errors++; $display("FAIL jump_priority got=%b exp=0011", {stall_if_o, stall_id_o, flush_id_o, flush_ex_o});
        end
      end
      if (flush_id_o && flush_ex_o) flushes++;
      tick();
    end
    checks++;
    if (flushes !== P) begin errors++; $display("FAIL jump_flush_count got=%0d exp=%0d", flushes, P); end
  endtask

  task automatic test_lsu_wait();
    int stalls = 0;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      if (c < 4) begin rd_addr_ex_i = 5'd4; rd_wr_en_ex_i = 1'b1; lsu_req_ex_i = 1'b1; end
      lsu_ready_i = (c >= 3);
      @(negedge clk);
      checks++;
      if (got !== model_out()) begin errors++; $display("FAIL lsu_wait cyc%0d got=%b exp=%b", c, got, model_out()); end
      if (stall_if_o && stall_id_o && stall_ex_o) stalls++;
      if (c == 3) begin
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o} !== 3'b000) begin
          errors++; $display("FAIL lsu_ready_drop got=%b exp=000", {stall_if_o, stall_id_o, stall_ex_o});
        end
      end
      tick();
    end
    checks++;
    if (stalls !== 3) begin errors++; $display("FAIL lsu_stall_count got=%0d exp=3", stalls); end
  endtask

  task automatic test_reset_mid_flush();
    idle_inputs();
    jump_taken_ex_i = 1'b1;
    tick();
    jump_taken_ex_i = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if (got !== 9'd0) begin errors++; $display("FAIL reset_mid_flush got=%b exp=%b", got, 9'd0); end
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (flush_id_o !== 1'b0 || flush_ex_o !== 1'b0) begin
        errors++; $display("FAIL post_reset_flush cyc%0d got=%b%b exp=00", c, flush_id_o, flush_ex_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      rs1_addr_id_i = 5'($urandom_range(0, 3)); rs2_addr_id_i = 5'($urandom_range(0, 3));
      rs1_used_id_i = 1'($urandom_range(0, 1)); rs2_used_id_i = 1'($urandom_range(0, 1));
      rd_addr_ex_i = 5'($urandom_range(0, 3)); rd_wr_en_ex_i = 1'($urandom_range(0, 1));
      rd_addr_wb_i = 5'($urandom_range(0, 3)); rd_wr_en_wb_i = 1'($urandom_range(0, 1));
      lsu_req_ex_i = ($urandom_range(0, 2) == 0); lsu_we_ex_i = 1'($urandom_range(0, 1));
      lsu_ready_i = 1'($urandom_range(0, 1));
      jump_taken_ex_i = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      checks++;
      if (got !== model_out()) begin errors++; $display("FAIL random cyc%0d got=%b exp=%b", c, got, model_out()); end
      tick();
    end
    rst_i = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_raw();
    test_load_use();
    test_jump(1'b0);
    test_jump(1'b1);
    test_lsu_wait();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
